// File: rtl/jtkcpu_busarb.sv
// KCPU external bus arbiter: CPU owns the bus by default, a secondary
// DMA master is granted at CPU slot boundaries with burst limiting.
module jtkcpu_busarb #(
  parameter int DMA_BURST = 8,
  parameter int CPU_MIN   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen2,
  input  logic        halt,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_dtack,
  input  logic        dma_req,
  input  logic [23:0] dma_addr,
  input  logic        dma_we,
  input  logic [7:0]  dma_dout,
  output logic [7:0]  dma_din,
  output logic        dma_ack,
  output logic [23:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  input  logic        mem_ok,
  output logic        owner
);

  localparam int BW = $clog2(DMA_BURST + 1);
  localparam int GW = $clog2(CPU_MIN + 1);

  localparam logic [0:0] ST_CPU = 1'b0;
  localparam logic [0:0] ST_DMA = 1'b1;

  localparam logic [BW-1:0] BLAST = BW'(DMA_BURST - 1);
  localparam logic [BW-1:0] BMAX  = BW'(DMA_BURST);
  localparam logic [GW-1:0] GLOAD = GW'(CPU_MIN);

  logic [0:0]    owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ack_q, ack_d;
  logic [7:0]    din_q, din_d;
  logic          limit;

  // burst limit only binds while the CPU is running
  assign limit = ~halt & (burst_q >= BLAST);

  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    ack_d   = 1'b0;
    din_d   = din_q;
    if (cen2) begin
      if (owner_q == ST_CPU) begin
        if (mem_ok) begin
          if (dma_req && (gap_q == '0 || halt)) begin
            owner_d = ST_DMA;
            burst_d = '0;
          end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
          end
        end
      end else begin
        if (!dma_req) begin
          // requester gave up: abandon access, no ack
          owner_d = ST_CPU;
          gap_d   = GLOAD;
        end else if (mem_ok) begin
          ack_d = 1'b1;
          din_d = mem_din;
          if (burst_q != BMAX) burst_d = burst_q + 1'b1;
          if (limit) begin
            owner_d = ST_CPU;
            gap_d   = GLOAD;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= ST_CPU;
      burst_q <= '0;
      gap_q   <= '0;
      ack_q   <= 1'b0;
      din_q   <= 8'h00;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      din_q   <= din_d;
    end
  end

  assign owner     = owner_q[0];
  assign dma_ack   = ack_q;
  assign dma_din   = din_q;
  assign cpu_din   = mem_din;
  assign cpu_dtack = ~owner_q[0] & mem_ok & rst_n;
  assign mem_addr  = owner_q[0] ? dma_addr : cpu_addr;
  assign mem_dout  = owner_q[0] ? dma_dout : cpu_dout;
  assign mem_we    = rst_n & (owner_q[0] ? dma_we : cpu_we);

endmodule
